mod_counter_n: RTL and testbench

- Parametrised modulo-N digit counter for the stopwatch datapath.
- Generalises the fixed mod-6 seconds digit to any width and modulus.
- Adds up/down counting, synchronous clear, parallel load with range protection, a cascade terminal-count output and a registered wrap pulse.
- Instances chain via tc_out -> enable to build seconds and minutes digits.

---
 rtl/mod_counter_n.sv | 61 ++++++
 tb/tb_mod_counter_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_n.sv
// Modulo-N up/down digit counter with clear, range-protected load,
// combinational cascade terminal count and a registered wrap pulse.
module mod_counter_n #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 6,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             tc_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VALUE);
  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic w_at_max;
  logic w_at_min;
  logic w_load_ok;

  always_comb begin
    w_at_max  = (out == MAX_V);
    w_at_min  = (out == '0);
    w_load_ok = ({1'b0, load_value} < MOD_EXT);
  end

  assign tc_out = enable & ~clear & ~load & (up_down ? w_at_max : w_at_min);

  // Boundary is tested before stepping, so out+1 / out-1 never leave range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= RST_V;
      wrap <= 1'b0;
    end else if (clear) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= w_load_ok ? load_value : MAX_V;
      wrap <= 1'b0;
    end else if (enable) begin
      if (up_down) begin
        out  <= w_at_max ? '0 : out + WIDTH'(1);
        wrap <= w_at_max;
      end else begin
        out  <= w_at_min ? MAX_V : out - WIDTH'(1);
        wrap <= w_at_min;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter_n.sv
// Self-checking bench for mod_counter_n: directed scenarios plus randomized
// traffic against an arithmetic modulo reference model.
module tb_mod_counter_n;

  logic clk;
  logic reset;

  // mod-6 digit
  logic       en6, ud6, clr6, ld6;
  logic [2:0] lv6, out6;
  logic       tc6, wrap6;
  // full-range mod-8 digit, non-zero reset value
  logic       en8, ud8, clr8, ld8;
  logic [2:0] lv8, out8;
  logic       tc8, wrap8;
  // mod-2 digit
  logic       en2, ud2, clr2, ld2;
  logic [0:0] lv2, out2;
  logic       tc2, wrap2;
  // seconds (mod 6) -> minutes (mod 10) cascade
  logic       en_s, ud_c, clr_c, ld_c;
  logic [2:0] lv_s, out_s;
  logic [3:0] lv_m, out_m;
  logic       tc_s, wrap_s, tc_m, wrap_m;

  int total = 0;
  int bad   = 0;
  int m6, m8, m2, ms, mm;

  mod_counter_n #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) u6 (
    .clk(clk), .reset(reset), .enable(en6), .up_down(ud6), .clear(clr6),
    .load(ld6), .load_value(lv6), .out(out6), .tc_out(tc6), .wrap(wrap6));

  mod_counter_n #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(2)) u8 (
    .clk(clk), .reset(reset), .enable(en8), .up_down(ud8), .clear(clr8),
    .load(ld8), .load_value(lv8), .out(out8), .tc_out(tc8), .wrap(wrap8));

  mod_counter_n #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0)) u2 (
    .clk(clk), .reset(reset), .enable(en2), .up_down(ud2), .clear(clr2),
    .load(ld2), .load_value(lv2), .out(out2), .tc_out(tc2), .wrap(wrap2));

  mod_counter_n #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) u_sec (
    .clk(clk), .reset(reset), .enable(en_s), .up_down(ud_c), .clear(clr_c),
    .load(ld_c), .load_value(lv_s), .out(out_s), .tc_out(tc_s), .wrap(wrap_s));

  mod_counter_n #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_min (
    .clk(clk), .reset(reset), .enable(tc_s), .up_down(ud_c), .clear(clr_c),
    .load(ld_c), .load_value(lv_m), .out(out_m), .tc_out(tc_m), .wrap(wrap_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain modulo arithmetic on integers.
  function automatic int nxt(input int m, input int c, input bit en, input bit ud,
                             input bit clr, input bit ld, input int lv);
    if (clr) return 0;
    if (ld)  return (lv < m) ? lv : m - 1;
    if (en)  return ud ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  // A step crosses the boundary; equals the expected tc before the edge
  // and the expected wrap after it.
  function automatic bit crosses(input int m, input int c, input bit en, input bit ud,
                                 input bit clr, input bit ld);
    return !clr && !ld && en && (ud ? (c == m - 1) : (c == 0));
  endfunction

  task automatic test_reset();
    bit w;
    repeat (2) @(posedge clk);
    #1;
    m6 = 0; m8 = 2; m2 = 0; ms = 0; mm = 0;
    total++; if (out6 !== 3'd0) begin bad++; $display("FAIL reset_out6: got %0d want 0", out6); end
    total++; if (wrap6 !== 1'b0) begin bad++; $display("FAIL reset_wrap6: got %b want 0", wrap6); end
    total++; if (out8 !== 3'd2) begin bad++; $display("FAIL reset_out8: got %0d want 2", out8); end
    total++; if (wrap8 !== 1'b0) begin bad++; $display("FAIL reset_wrap8: got %b want 0", wrap8); end
    reset = 1'b1;
    en6 = 1; ud6 = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      m6 = nxt(6, m6, en6, ud6, clr6, ld6, int'(lv6));
      #1;
    end
    total++; if (out6 !== 3'd4) begin bad++; $display("FAIL reset_precount: got %0d want 4", out6); end
    en6 = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m6 = 0; m8 = 2;
    total++; if (out6 !== 3'd0) begin bad++; $display("FAIL reset_async: got %0d want 0", out6); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    w = wrap6;
    total++; if (out6 !== 3'd0 || w !== 1'b0) begin
      bad++; $display("FAIL reset_release: got out=%0d wrap=%b want 0/0", out6, w);
    end
  endtask

  task automatic test_up_wrap();
    int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
    en6 = 1; ud6 = 1; clr6 = 0; ld6 = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      total++; if (tc6 !== (m6 == 5)) begin bad++; $display("FAIL up_tc step%0d: got %b want %b", i, tc6, m6 == 5); end
      @(posedge clk);
      m6 = nxt(6, m6, en6, ud6, clr6, ld6, int'(lv6));
      #1;
      total++; if (out6 !== 3'(exp_seq[i])) begin bad++; $display("FAIL up_out step%0d: got %0d want %0d", i, out6, exp_seq[i]); end
      total++; if (wrap6 !== (i == 5)) begin bad++; $display("FAIL up_wrap step%0d: got %b want %b", i, wrap6, i == 5); end
    end
  endtask

  task automatic test_down_wrap();
    int exp_seq [3] = '{0, 5, 4};
    ud6 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (tc6 !== (m6 == 0)) begin bad++; $display("FAIL down_tc step%0d: got %b want %b", i, tc6, m6 == 0); end
      @(posedge clk);
      m6 = nxt(6, m6, en6, ud6, clr6, ld6, int'(lv6));
      #1;
      total++; if (out6 !== 3'(exp_seq[i])) begin bad++; $display("FAIL down_out step%0d: got %0d want %0d", i, out6, exp_seq[i]); end
      total++; if (wrap6 !== (i == 1)) begin bad++; $display("FAIL down_wrap step%0d: got %b want %b", i, wrap6, i == 1); end
    end
    en6 = 0;
  endtask

  task automatic test_load_clear();
    en6 = 0; ld6 = 1; lv6 = 3'd3;
    @(posedge clk); #1;
    total++; if (out6 !== 3'd3 || wrap6 !== 1'b0) begin bad++; $display("FAIL load3: got %0d/%b want 3/0", out6, wrap6); end
    lv6 = 3'd7;
    @(posedge clk); #1;
    total++; if (out6 !== 3'd5) begin bad++; $display("FAIL load_sat: got %0d want 5", out6); end
    ld6 = 0; en6 = 1; ud6 = 1; #1;
    total++; if (tc6 !== 1'b1) begin bad++; $display("FAIL tc_at_max: got %b want 1", tc6); end
    clr6 = 1; ld6 = 1; #1;
    total++; if (tc6 !== 1'b0) begin bad++; $display("FAIL tc_masked: got %b want 0", tc6); end
    @(posedge clk); #1;
    total++; if (out6 !== 3'd0 || wrap6 !== 1'b0) begin bad++; $display("FAIL clear_prio: got %0d/%b want 0/0", out6, wrap6); end
    clr6 = 0; ld6 = 0; en6 = 0;
    m6 = 0;
  endtask

  task automatic test_full_range();
    clr8 = 1;
    @(posedge clk); #1;
    clr8 = 0; m8 = 0;
    total++; if (out8 !== 3'd0) begin bad++; $display("FAIL fr_clear: got %0d want 0", out8); end
    en8 = 1; ud8 = 1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      total++; if (out8 !== 3'((i + 1) % 8)) begin bad++; $display("FAIL fr_out step%0d: got %0d want %0d", i, out8, (i + 1) % 8); end
      total++; if (wrap8 !== (i == 7)) begin bad++; $display("FAIL fr_wrap step%0d: got %b want %b", i, wrap8, i == 7); end
    end
    en8 = 0; m8 = 1;
  endtask

  task automatic test_random();
    bit e6, e8, t6, t8;
    for (int i = 0; i < 300; i++) begin
      en6 = ($urandom_range(3) != 0); ud6 = $urandom_range(1);
      clr6 = ($urandom_range(15) == 0); ld6 = ($urandom_range(7) == 0); lv6 = 3'($urandom_range(7));
      en8 = ($urandom_range(3) != 0); ud8 = $urandom_range(1);
      clr8 = ($urandom_range(15) == 0); ld8 = ($urandom_range(7) == 0); lv8 = 3'($urandom_range(7));
      #1;
      t6 = crosses(6, m6, en6, ud6, clr6, ld6);
      t8 = crosses(8, m8, en8, ud8, clr8, ld8);
      total++; if (tc6 !== t6) begin bad++; $display("FAIL rnd_tc6 it%0d: got %b want %b", i, tc6, t6); end
      total++; if (tc8 !== t8) begin bad++; $display("FAIL rnd_tc8 it%0d: got %b want %b", i, tc8, t8); end
      @(posedge clk);
      e6 = t6; e8 = t8;
      m6 = nxt(6, m6, en6, ud6, clr6, ld6, int'(lv6));
      m8 = nxt(8, m8, en8, ud8, clr8, ld8, int'(lv8));
      #1;
      total++; if (out6 !== 3'(m6) || wrap6 !== e6) begin bad++; $display("FAIL rnd_u6 it%0d: got %0d/%b want %0d/%b", i, out6, wrap6, m6, e6); end
      total++; if (out8 !== 3'(m8) || wrap8 !== e8) begin bad++; $display("FAIL rnd_u8 it%0d: got %0d/%b want %0d/%b", i, out8, wrap8, m8, e8); end
    end
    en6 = 0; clr6 = 0; ld6 = 0; en8 = 0; clr8 = 0; ld8 = 0;
  endtask

  task automatic test_cascade();
    bit ew;
    clr_c = 1;
    @(posedge clk); #1;
    clr_c = 0; ms = 0; mm = 0;
    total++; if (out_s !== 3'd0 || out_m !== 4'd0) begin bad++; $display("FAIL casc_clear: got %0d/%0d want 0/0", out_s, out_m); end
    en_s = 1;
    for (int i = 0; i < 60; i++) begin
      #1;
      total++; if (tc_s !== (ms == 5)) begin bad++; $display("FAIL casc_tc edge%0d: got %b want %b", i, tc_s, ms == 5); end
      @(posedge clk);
      ew = (ms == 5) && (mm == 9);
      if (ms == 5) mm = (mm + 1) % 10;
      ms = (ms + 1) % 6;
      #1;
      total++; if (out_s !== 3'(ms) || out_m !== 4'(mm)) begin
        bad++; $display("FAIL casc_out edge%0d: got %0d:%0d want %0d:%0d", i, out_m, out_s, mm, ms);
      end
      total++; if (wrap_m !== ew) begin bad++; $display("FAIL casc_minwrap edge%0d: got %b want %b", i, wrap_m, ew); end
    end
    total++; if (out_s !== 3'd0 || out_m !== 4'd0 || wrap_m !== 1'b1) begin
      bad++; $display("FAIL casc_final: got %0d:%0d wrap=%b want 0:0 wrap=1", out_m, out_s, wrap_m);
    end
    en_s = 0;
  endtask

  task automatic test_back_to_back();
    bit ew;
    // Alternating direction on a mod-2 digit wraps on every edge.
    en2 = 1;
    for (int i = 0; i < 10; i++) begin
      ud2 = (i < 4) ? 1'b1 : ((m2 == 0) ? 1'b0 : 1'b1);
      @(posedge clk);
      ew = crosses(2, m2, en2, ud2, clr2, ld2);
      m2 = nxt(2, m2, en2, ud2, clr2, ld2, int'(lv2));
      #1;
      total++; if (out2 !== 1'(m2) || wrap2 !== ew) begin bad++; $display("FAIL b2b it%0d: got %0d/%b want %0d/%b", i, out2, wrap2, m2, ew); end
    end
    en2 = 0;
    @(posedge clk); #1;
    total++; if (wrap2 !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", wrap2); end
  endtask

  initial begin
    reset = 1'b0;
    en6 = 0; ud6 = 0; clr6 = 0; ld6 = 0; lv6 = '0;
    en8 = 0; ud8 = 0; clr8 = 0; ld8 = 0; lv8 = '0;
    en2 = 0; ud2 = 0; clr2 = 0; ld2 = 0; lv2 = '0;
    en_s = 0; ud_c = 1; clr_c = 0; ld_c = 0; lv_s = '0; lv_m = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clear();
    test_full_range();
    test_random();
    test_cascade();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
